// File: rtl/serial_frame_checker.sv
// Streaming frame checker: per-frame divisibility, phase parity, overlapping pattern count
// and length over an MSB-first serial bit stream, one result record per frame.
module serial_frame_checker #(
    parameter int           MOD       = 3,
    parameter int           PAR_PHASE = 1,
    parameter int           PAT_W     = 3,
    parameter logic [PAT_W-1:0] PAT   = 3'b010,
    parameter int           CNT_W     = 8,
    parameter int           LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_div,
    output logic             res_par,
    output logic             res_found,
    output logic [CNT_W-1:0] res_count,
    output logic [LEN_W-1:0] res_len
);

    localparam int   RW        = $clog2(MOD);
    localparam int   HW        = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam int   FW        = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic PHASE_SEL = (PAR_PHASE % 2) == 1;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [RW-1:0]    r_residue;
    logic             r_par;
    logic [HW-1:0]    r_hist;
    logic             r_phase;
    logic [FW-1:0]    r_fill;
    logic [CNT_W-1:0] r_count;
    logic [LEN_W-1:0] r_len;

    logic             r_res_div;
    logic             r_res_par;
    logic             r_res_found;
    logic [CNT_W-1:0] r_res_count;
    logic [LEN_W-1:0] r_res_len;

    logic             w_accept;
    logic             w_frame_end;
    logic             w_release;
    logic [RW:0]      w_dbl;
    logic [RW-1:0]    w_residue_nxt;
    logic             w_par_nxt;
    logic [PAT_W-1:0] w_window;
    logic [HW-1:0]    w_hist_nxt;
    logic             w_fill_ok;
    logic             w_match;
    logic [CNT_W-1:0] w_count_nxt;
    logic [LEN_W-1:0] w_len_nxt;

    assign in_ready    = ~rst & (r_state == S_COLLECT);
    assign res_valid   = (r_state == S_HOLD);
    assign w_accept    = in_valid & in_ready;
    assign w_frame_end = w_accept & in_last;
    assign w_release   = res_valid & res_ready;

    // Residue stays below MOD, so 2*r+b is below 2*MOD and one conditional subtract suffices.
    assign w_dbl         = {r_residue, in_bit};
    assign w_residue_nxt = (w_dbl >= (RW+1)'(MOD)) ? RW'(w_dbl - (RW+1)'(MOD)) : RW'(w_dbl);

    assign w_par_nxt = r_par ^ (in_bit & (r_phase == PHASE_SEL));

    generate
        if (PAT_W > 1) begin : g_hist
            assign w_window   = {r_hist[PAT_W-2:0], in_bit};
            assign w_hist_nxt = w_window[PAT_W-2:0];
        end else begin : g_nohist
            assign w_window   = in_bit;
            assign w_hist_nxt = r_hist;
        end
    endgenerate

    // Fill counter reaching PAT_W-1 means the window holds PAT_W bits of this frame.
    assign w_fill_ok   = (r_fill == FW'(PAT_W - 1));
    assign w_match     = w_fill_ok & (w_window == PAT);
    assign w_count_nxt = (w_match & ~(&r_count)) ? r_count + 1'b1 : r_count;
    assign w_len_nxt   = (&r_len) ? r_len : r_len + 1'b1;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_frame_end) w_state_nxt = S_HOLD;
            S_HOLD:    if (res_ready)   w_state_nxt = S_COLLECT;
            default:   w_state_nxt = S_COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_residue <= '0;
            r_par     <= 1'b0;
            r_hist    <= '0;
            r_phase   <= 1'b0;
            r_fill    <= '0;
            r_count   <= '0;
            r_len     <= '0;
        end else if (w_accept) begin
            r_residue <= w_residue_nxt;
            r_par     <= w_par_nxt;
            r_hist    <= w_hist_nxt;
            r_phase   <= ~r_phase;
            r_fill    <= w_fill_ok ? r_fill : r_fill + 1'b1;
            r_count   <= w_count_nxt;
            r_len     <= w_len_nxt;
        end
    end

    // Result record includes the last bit and holds until the next frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_div   <= 1'b0;
            r_res_par   <= 1'b0;
            r_res_found <= 1'b0;
            r_res_count <= '0;
            r_res_len   <= '0;
        end else if (w_frame_end) begin
            r_res_div   <= (w_residue_nxt == '0);
            r_res_par   <= w_par_nxt;
            r_res_found <= (w_count_nxt != '0);
            r_res_count <= w_count_nxt;
            r_res_len   <= w_len_nxt;
        end
    end

    assign res_div   = r_res_div;
    assign res_par   = r_res_par;
    assign res_found = r_res_found;
    assign res_count = r_res_count;
    assign res_len   = r_res_len;

endmodule

// File: tb/tb_serial_frame_checker.sv
// Directed bench for serial_frame_checker: default configuration plus a MOD=5 / PAT=11 variant.
module tb_serial_frame_checker;

    logic       clk = 1'b0;
    logic       rst;
    int         n_checks = 0;
    int         n_errors = 0;

    logic       in_valid_a, in_bit_a, in_last_a, in_ready_a;
    logic       res_valid_a, res_ready_a, res_div_a, res_par_a, res_found_a;
    logic [7:0] res_count_a, res_len_a;

    logic       in_valid_b, in_bit_b, in_last_b, in_ready_b;
    logic       res_valid_b, res_ready_b, res_div_b, res_par_b, res_found_b;
    logic [7:0] res_count_b, res_len_b;

    always #5 clk = ~clk;

    serial_frame_checker dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_bit(in_bit_a), .in_last(in_last_a), .in_ready(in_ready_a),
        .res_valid(res_valid_a), .res_ready(res_ready_a),
        .res_div(res_div_a), .res_par(res_par_a), .res_found(res_found_a),
        .res_count(res_count_a), .res_len(res_len_a)
    );

    serial_frame_checker #(
        .MOD(5), .PAR_PHASE(0), .PAT_W(2), .PAT(2'b11), .CNT_W(8), .LEN_W(8)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_bit(in_bit_b), .in_last(in_last_b), .in_ready(in_ready_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b),
        .res_div(res_div_b), .res_par(res_par_b), .res_found(res_found_b),
        .res_count(res_count_b), .res_len(res_len_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat at the negedge and hold it until an edge with in_ready high.
    task automatic beat_a(input logic b, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid_a = 1'b1; in_bit_a = b; in_last_a = last;
        while (!in_ready_a && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            check("a_ready_timeout", 32'd0, 32'd1);
            in_valid_a = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid_a = 1'b0; in_last_a = 1'b0;
    endtask

    task automatic beat_b(input logic b, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid_b = 1'b1; in_bit_b = b; in_last_b = last;
        while (!in_ready_b && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            check("b_ready_timeout", 32'd0, 32'd1);
            in_valid_b = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid_b = 1'b0; in_last_b = 1'b0;
    endtask

    task automatic send_a(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) beat_a(v[n-1-i], i == n - 1);
    endtask

    // Called right after the last beat: the record must be valid in the very next cycle.
    task automatic expect_a(input string tag, input logic div, input logic par, input logic found,
                            input logic [7:0] cnt, input logic [7:0] len);
        @(negedge clk);
        check({tag, "_valid"}, res_valid_a, 1'b1);
        check({tag, "_ready"}, in_ready_a, 1'b0);
        check({tag, "_div"},   res_div_a, div);
        check({tag, "_par"},   res_par_a, par);
        check({tag, "_found"}, res_found_a, found);
        check({tag, "_count"}, res_count_a, cnt);
        check({tag, "_len"},   res_len_a, len);
    endtask

    task automatic ack_a(input string tag, input logic [7:0] len);
        res_ready_a = 1'b1;
        @(posedge clk);
        #1 res_ready_a = 1'b0;
        @(negedge clk);
        check({tag, "_ack_valid"}, res_valid_a, 1'b0);
        check({tag, "_ack_ready"}, in_ready_a, 1'b1);
        check({tag, "_ack_len_held"}, res_len_a, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid_a = 0; in_bit_a = 0; in_last_a = 0; res_ready_a = 0;
        in_valid_b = 0; in_bit_b = 0; in_last_b = 0; res_ready_b = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready_a, 1'b0);
        check("rst_res_valid", res_valid_a, 1'b0);
        check("rst_res_len", res_len_a, 8'd0);
        check("rst_res_count", res_count_a, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_a, 1'b1);

        // 1,1,0,0 = 12
        send_a(64'b1100, 4);
        expect_a("t1", 1'b1, 1'b1, 1'b0, 8'd0, 8'd4);
        ack_a("t1", 8'd4);

        // 0,1,0,1,0 = 10, two overlapping 010
        send_a(64'b01010, 5);
        expect_a("t2", 1'b0, 1'b0, 1'b1, 8'd2, 8'd5);
        ack_a("t2", 8'd5);

        // 1,1 = 3, then consumer stalls while upstream keeps offering beats
        send_a(64'b11, 2);
        expect_a("t3a", 1'b1, 1'b1, 1'b0, 8'd0, 8'd2);
        in_valid_a = 1'b1; in_bit_a = 1'b1; in_last_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", res_valid_a, 1'b1);
            check("t3_hold_ready", in_ready_a, 1'b0);
            check("t3_hold_len", res_len_a, 8'd2);
            check("t3_hold_par", res_par_a, 1'b1);
        end
        in_valid_a = 1'b0; in_last_a = 1'b0;
        ack_a("t3a", 8'd2);
        send_a(64'b010, 3);
        expect_a("t3b", 1'b0, 1'b1, 1'b1, 8'd1, 8'd3);
        ack_a("t3b", 8'd3);

        // Partial frame 1,1,1 aborted by reset
        beat_a(1'b1, 1'b0);
        beat_a(1'b1, 1'b0);
        beat_a(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t4_rst_valid", res_valid_a, 1'b0);
        check("t4_rst_len", res_len_a, 8'd0);
        check("t4_rst_ready", in_ready_a, 1'b1);
        send_a(64'b010, 3);
        expect_a("t4", 1'b0, 1'b1, 1'b1, 8'd1, 8'd3);
        ack_a("t4", 8'd3);

        // 600-bit "01" x300: value = sum of 4^k, 300 terms, divisible by 3; 299 matches
        for (int i = 0; i < 600; i++) beat_a(logic'(i % 2), i == 599);
        expect_a("t5", 1'b1, 1'b0, 1'b1, 8'd255, 8'd255);
        ack_a("t5", 8'd255);

        // Variant instance (divisor 5, even phase, pattern 11): 1,1,1,1 = 15, then single-bit 0
        for (int i = 0; i < 4; i++) beat_b(1'b1, i == 3);
        @(negedge clk);
        check("t6a_valid", res_valid_b, 1'b1);
        check("t6a_div", res_div_b, 1'b1);
        check("t6a_par", res_par_b, 1'b0);
        check("t6a_found", res_found_b, 1'b1);
        check("t6a_count", res_count_b, 8'd3);
        check("t6a_len", res_len_b, 8'd4);
        res_ready_b = 1'b1;
        @(posedge clk);
        #1 res_ready_b = 1'b0;
        beat_b(1'b0, 1'b1);
        @(negedge clk);
        check("t6b_valid", res_valid_b, 1'b1);
        check("t6b_div", res_div_b, 1'b1);
        check("t6b_par", res_par_b, 1'b0);
        check("t6b_found", res_found_b, 1'b0);
        check("t6b_count", res_count_b, 8'd0);
        check("t6b_len", res_len_b, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
